// File: rtl/seg_score_display_if.sv
// rtl/seg_score_display_if.sv - score input and 7-segment display bundle
interface seg_score_display_if;
   logic       segclk;
   logic [9:0] score;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp;
   logic       busy;

   // display driver side: consumes strobe and score, drives the panel
   modport master (
      input  segclk,
      input  score,
      output seg,
      output an,
      output dp,
      output busy
   );

   // source side: supplies strobe and score, observes the panel
   modport slave (
      output segclk,
      output score,
      input  seg,
      input  an,
      input  dp,
      input  busy
   );
endinterface

// File: rtl/seg_score_display.sv
// rtl/seg_score_display.sv - binary score to multiplexed 4-digit 7-segment display
module seg_score_display #(
   parameter int BLANK_LEADING = 1,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                 clk,
   input  logic                 clr,
   seg_score_display_if.master  bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SHIFT  = 2'd1;
   localparam logic [1:0] COMMIT = 2'd2;

   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_d1;
   logic                   tick;

   logic [1:0]  state;
   logic [9:0]  bin;
   logic [15:0] bcd;
   logic [15:0] bcd_adj;
   logic [3:0]  cnt;
   logic        busy_r;
   logic [15:0] digits;

   logic [1:0]  idx;
   logic [6:0]  seg_r;
   logic [3:0]  an_r;
   logic [3:0]  cur_digit;
   logic        blank;
   logic [6:0]  seg_next;

   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      case (d)
         4'd0:    seg_enc = 7'h40;
         4'd1:    seg_enc = 7'h79;
         4'd2:    seg_enc = 7'h24;
         4'd3:    seg_enc = 7'h30;
         4'd4:    seg_enc = 7'h19;
         4'd5:    seg_enc = 7'h12;
         4'd6:    seg_enc = 7'h02;
         4'd7:    seg_enc = 7'h78;
         4'd8:    seg_enc = 7'h00;
         4'd9:    seg_enc = 7'h10;
         default: seg_enc = 7'h7F;
      endcase
   endfunction

   // bring segclk into the clk domain and keep one extra flop for edge detection
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         sync    <= '0;
         sync_d1 <= 1'b0;
      end else begin
         sync    <= {sync[SYNC_STAGES-2:0], bus.segclk};
         sync_d1 <= sync[SYNC_STAGES-1];
      end
   end

   assign tick = sync[SYNC_STAGES-1] & ~sync_d1;

   // double-dabble correction: every nibble of 5 or more gets +3 before the shift
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   // conversion FSM; digits only change in COMMIT so the panel never sees partial results
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state  <= IDLE;
         bin    <= '0;
         bcd    <= '0;
         cnt    <= '0;
         busy_r <= 1'b0;
         digits <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (tick) begin
                  bin    <= bus.score;
                  bcd    <= '0;
                  cnt    <= '0;
                  busy_r <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               {bcd, bin} <= {bcd_adj, bin} << 1;
               cnt        <= cnt + 4'd1;
               if (cnt == 4'd9) begin
                  state <= COMMIT;
               end
            end
            COMMIT: begin
               digits <= bcd;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // select the digit under the scan index and apply leading-zero blanking
   always_comb begin
      cur_digit = digits[3:0];
      blank     = 1'b0;
      case (idx)
         2'd0: begin
            cur_digit = digits[3:0];
            blank     = 1'b0;
         end
         2'd1: begin
            cur_digit = digits[7:4];
            blank     = (digits[15:4] == 12'd0);
         end
         2'd2: begin
            cur_digit = digits[11:8];
            blank     = (digits[15:8] == 8'd0);
         end
         default: begin
            cur_digit = digits[15:12];
            blank     = (digits[15:12] == 4'd0);
         end
      endcase
      seg_next = (blank && (BLANK_LEADING != 0)) ? 7'h7F : seg_enc(cur_digit);
   end

   // scan: each tick presents the current digit and moves the index on
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         idx   <= 2'd0;
         seg_r <= 7'h7F;
         an_r  <= 4'hF;
      end else if (tick) begin
         seg_r <= seg_next;
         an_r  <= ~(4'b0001 << idx);
         idx   <= idx + 2'd1;
      end
   end

   assign bus.seg  = seg_r;
   assign bus.an   = an_r;
   assign bus.dp   = 1'b1;
   assign bus.busy = busy_r;

endmodule

// File: tb/tb_seg_score_display.sv
// tb/tb_seg_score_display.sv - scoreboard bench for seg_score_display
module tb_seg_score_display;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       segclk = 1'b0;
   logic [9:0] score = '0;

   always #5 clk = ~clk;

   seg_score_display_if if0 ();
   seg_score_display_if if1 ();

   assign if0.segclk = segclk;
   assign if0.score  = score;
   assign if1.segclk = segclk;
   assign if1.score  = score;

   seg_score_display #(.BLANK_LEADING(1), .SYNC_STAGES(2)) dut0 (
      .clk (clk),
      .clr (clr),
      .bus (if0.master)
   );

   seg_score_display #(.BLANK_LEADING(0), .SYNC_STAGES(3)) dut1 (
      .clk (clk),
      .clr (clr),
      .bus (if1.master)
   );

   int total = 0;
   int bad   = 0;

   logic [10:0] q0 [$];
   logic [10:0] q1 [$];

   // reference model state, one slot per DUT
   bit         hist  [2][4];
   int         m_idx [2];
   int         m_dig [2][4];
   int         m_left[2];
   int         m_pend[2];
   logic [3:0] m_an  [2] = '{4'hF, 4'hF};
   int         ms;
   bit         mtk;
   logic [3:0] me_an;

   function automatic int stages(int k);
      return (k == 0) ? 2 : 3;
   endfunction

   function automatic logic [6:0] enc(int d);
      case (d)
         0: return 7'h40;
         1: return 7'h79;
         2: return 7'h24;
         3: return 7'h30;
         4: return 7'h19;
         5: return 7'h12;
         6: return 7'h02;
         7: return 7'h78;
         8: return 7'h00;
         9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [6:0] show(int k, int i);
      bit nz = 0;
      for (int j = i; j < 4; j++) if (m_dig[k][j] != 0) nz = 1;
      if (k == 0 && i > 0 && !nz) return 7'h7F;
      return enc(m_dig[k][i]);
   endfunction

   task automatic push(int k, logic [10:0] v);
      if (k == 0) q0.push_back(v);
      else        q1.push_back(v);
   endtask

   // behavioural model: strobe delayed by the synchronizer depth, 11-cycle conversion by arithmetic
   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) begin
               hist[k][j]  = 1'b0;
               m_dig[k][j] = 0;
            end
            m_idx[k]  = 0;
            m_left[k] = 0;
            if (m_an[k] != 4'hF) begin
               push(k, {4'hF, 7'h7F});
               m_an[k] = 4'hF;
            end
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            ms  = stages(k);
            mtk = hist[k][ms-1] && !hist[k][ms];
            if (mtk) begin
               me_an = ~(4'b0001 << m_idx[k]);
               push(k, {me_an, show(k, m_idx[k])});
               m_an[k]  = me_an;
               m_idx[k] = (m_idx[k] + 1) % 4;
            end
            if (m_left[k] > 0) begin
               m_left[k]--;
               if (m_left[k] == 0) begin
                  m_dig[k][0] = m_pend[k] % 10;
                  m_dig[k][1] = (m_pend[k] / 10) % 10;
                  m_dig[k][2] = (m_pend[k] / 100) % 10;
                  m_dig[k][3] = m_pend[k] / 1000;
               end
            end else if (mtk) begin
               m_pend[k] = int'(score);
               m_left[k] = 11;
            end
            for (int j = ms; j > 0; j--) hist[k][j] = hist[k][j-1];
            hist[k][0] = segclk;
         end
      end
   end

   // monitor: busy/dp every cycle, and one scoreboard entry per change of the anode pattern
   logic [3:0] p_an [2] = '{4'hF, 4'hF};
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         logic [3:0]  an_k;
         logic [6:0]  seg_k;
         logic        busy_k;
         logic        dp_k;
         logic [10:0] exp_v;
         an_k   = (k == 0) ? if0.an   : if1.an;
         seg_k  = (k == 0) ? if0.seg  : if1.seg;
         busy_k = (k == 0) ? if0.busy : if1.busy;
         dp_k   = (k == 0) ? if0.dp   : if1.dp;
         total++;
         if (busy_k !== (m_left[k] > 0) || dp_k !== 1'b1) begin
            bad++;
            $display("FAIL busy_dp dut%0d t=%0t: got busy=%0b dp=%0b, want busy=%0b dp=1",
                     k, $time, busy_k, dp_k, (m_left[k] > 0));
         end
         if (an_k !== p_an[k]) begin
            p_an[k] = an_k;
            total++;
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
               bad++;
               $display("FAIL scan dut%0d t=%0t: got an=%h seg=%h, want no change", k, $time, an_k, seg_k);
            end else begin
               exp_v = (k == 0) ? q0.pop_front() : q1.pop_front();
               if ({an_k, seg_k} !== exp_v) begin
                  bad++;
                  $display("FAIL scan dut%0d t=%0t: got an=%h seg=%h, want an=%h seg=%h",
                           k, $time, an_k, seg_k, exp_v[10:7], exp_v[6:0]);
               end
            end
         end
      end
   end

   task automatic chk(string name, logic [31:0] got, logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rise(int hi, int lo);
      segclk = 1'b1;
      cyc(hi);
      segclk = 1'b0;
      cyc(lo);
   endtask

   task automatic wait_busy(string name);
      int n = 0;
      while (if0.busy !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(name, {31'd0, if0.busy}, 32'd1);
   endtask

   initial begin
      int n;
      logic [3:0] p;

      // reset held with the strobe toggling
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         segclk = ~segclk;
         #1;
         chk("reset_dut0", {if0.seg, if0.an, if0.dp, if0.busy}, {7'h7F, 4'hF, 1'b1, 1'b0});
         chk("reset_dut1", {if1.seg, if1.an, if1.dp, if1.busy}, {7'h7F, 4'hF, 1'b1, 1'b0});
      end
      @(negedge clk);
      segclk = 1'b0;
      clr    = 1'b1;
      cyc(3);
      chk("an_before_tick0", {28'd0, if0.an}, 32'hF);
      chk("an_before_tick1", {28'd0, if1.an}, 32'hF);

      // single conversion of the maximum value
      score  = 10'd1023;
      segclk = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (if0.busy === 1'b1) n++;
      end
      chk("busy_cycles", n, 11);
      segclk = 1'b0;
      cyc(5);
      repeat (4) rise(6, 6);

      // blanking patterns
      score = 10'd7;
      repeat (5) rise(6, 6);
      score = 10'd0;
      repeat (5) rise(8, 8);

      // score change and extra tick during SHIFT
      score  = 10'd250;
      segclk = 1'b1;
      wait_busy("busy_mid");
      cyc(2);
      score  = 10'd999;
      segclk = 1'b0;
      cyc(2);
      segclk = 1'b1;
      cyc(10);
      segclk = 1'b0;
      cyc(4);
      repeat (6) rise(6, 6);

      // asynchronous reset during SHIFT
      score  = 10'd345;
      segclk = 1'b1;
      wait_busy("busy_rst");
      cyc(4);
      #2 clr = 1'b0;
      #1;
      chk("async_rst_dut0", {if0.seg, if0.an, if0.busy}, {7'h7F, 4'hF, 1'b0});
      chk("async_rst_dut1", {if1.seg, if1.an, if1.busy}, {7'h7F, 4'hF, 1'b0});
      cyc(3);
      segclk = 1'b0;
      clr    = 1'b1;
      cyc(3);
      repeat (5) rise(6, 6);

      // long high strobe: one advance only, falling edge ignored
      cyc(5);
      p = if0.an;
      n = 0;
      segclk = 1'b1;
      for (int i = 0; i < 130; i++) begin
         if (i == 100) segclk = 1'b0;
         @(negedge clk);
         if (if0.an !== p) begin
            n++;
            p = if0.an;
         end
      end
      chk("hold_high_advances", n, 1);

      // random scores and strobe timing
      repeat (150) begin
         score = 10'($urandom_range(0, 1023));
         if ($urandom_range(0, 9) == 0) score = ($urandom_range(0, 1) == 1) ? 10'd1023 : 10'd0;
         rise($urandom_range(1, 14), $urandom_range(1, 14));
      end

      cyc(30);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end

endmodule
